// File: rtl/food_placer.sv
// food_placer: picks a random free playfield cell for the next food item.
// Steps an external generator, range-checks the candidate, asks an occupancy
// responder whether the cell is taken, and retries up to MAX_TRIES times.
module food_placer #(
  parameter int WIDTH     = 20,
  parameter int HEIGHT    = 15,
  parameter int MAX_TRIES = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       rng_update,
  input  logic [3:0] rng4,
  input  logic [4:0] rng5,
  output logic       occ_req,
  output logic [4:0] occ_x,
  output logic [3:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [4:0] food_x,
  output logic [3:0] food_y,
  output logic [4:0] tries
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    SAMPLE = 3'd2,
    QUERY  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [5:0] WIDTH_L  = 6'(WIDTH);
  localparam logic [4:0] HEIGHT_L = 5'(HEIGHT);
  localparam logic [4:0] MAX_L    = 5'(MAX_TRIES);

  state_t     state_q, state_d;
  logic [4:0] tries_q, tries_d;
  logic       fail_q, fail_d;
  logic [4:0] food_x_q, food_x_d;
  logic [3:0] food_y_q, food_y_d;
  logic [4:0] occ_x_q, occ_x_d;
  logic [3:0] occ_y_q, occ_y_d;

  logic in_range;
  logic can_retry;

  // Candidate must lie inside the playfield; retries allowed while budget remains.
  always_comb begin
    in_range  = ({1'b0, rng5} < WIDTH_L) && ({1'b0, rng4} < HEIGHT_L);
    can_retry = (tries_q < MAX_L);
  end

  // State and datapath registers; reset returns everything to zero and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tries_q  <= '0;
      fail_q   <= 1'b0;
      food_x_q <= '0;
      food_y_q <= '0;
      occ_x_q  <= '0;
      occ_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      fail_q   <= fail_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      occ_x_q  <= occ_x_d;
      occ_y_q  <= occ_y_d;
    end
  end

  // Next-state selection; abort overrides everything except an IDLE start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STEP;
      STEP:    state_d = SAMPLE;
      SAMPLE: begin
        if (in_range)       state_d = QUERY;
        else if (can_retry) state_d = STEP;
        else                state_d = DONE;
      end
      QUERY: begin
        if (occ_ack) begin
          if (!occ_hit)       state_d = DONE;
          else if (can_retry) state_d = STEP;
          else                state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Datapath updates: try counter, candidate latch, result and fail flag.
  always_comb begin
    tries_d  = tries_q;
    fail_d   = fail_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    occ_x_d  = occ_x_q;
    occ_y_d  = occ_y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tries_d = '0;
          fail_d  = 1'b0;
        end
      end
      STEP: begin
        // Saturating: the FSM never re-enters STEP at the limit, this is a backstop.
        if (can_retry) tries_d = tries_q + 5'd1;
      end
      SAMPLE: begin
        // Generator has already advanced on the STEP edge, so rng values are fresh.
        occ_x_d = rng5;
        occ_y_d = rng4;
        if (!abort && !in_range && !can_retry) fail_d = 1'b1;
      end
      QUERY: begin
        if (!abort && occ_ack) begin
          if (!occ_hit) begin
            food_x_d = occ_x_q;
            food_y_d = occ_y_q;
            fail_d   = 1'b0;
          end else if (!can_retry) begin
            fail_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    rng_update = (state_q == STEP);
    occ_req    = (state_q == QUERY);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

  assign occ_x  = occ_x_q;
  assign occ_y  = occ_y_q;
  assign fail   = fail_q;
  assign food_x = food_x_q;
  assign food_y = food_y_q;
  assign tries  = tries_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer with a behavioural 4/5-bit generator model.
// Candidate sequence from seed (lfsr4=1011, lfsr5=00111), one per step:
// (15,6) (31,12) (30,9) (28,2) (24,4) (17,8)
module tb_food_placer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, occ_ack, occ_hit;
  logic       rng_update, occ_req, busy, done, fail;
  logic [3:0] l4, occ_y, food_y;
  logic [4:0] l5, occ_x, food_x, tries;

  logic       b_start, b_abort, b_ack, b_hit;
  logic       b_rng_update, b_occ_req, b_busy, b_done, b_fail;
  logic [3:0] b_l4, b_occ_y, b_food_y;
  logic [4:0] b_l5, b_occ_x, b_food_x, b_tries;

  logic gen_rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   pulses = 0;
  int   b_pulses = 0;

  always #5 clk = ~clk;

  food_placer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rng_update(rng_update), .rng4(l4), .rng5(l5),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit),
    .busy(busy), .done(done), .fail(fail),
    .food_x(food_x), .food_y(food_y), .tries(tries)
  );

  food_placer #(.MAX_TRIES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .rng_update(b_rng_update), .rng4(b_l4), .rng5(b_l5),
    .occ_req(b_occ_req), .occ_x(b_occ_x), .occ_y(b_occ_y),
    .occ_ack(b_ack), .occ_hit(b_hit),
    .busy(b_busy), .done(b_done), .fail(b_fail),
    .food_x(b_food_x), .food_y(b_food_y), .tries(b_tries)
  );

  // Generator model: left-shift LFSRs, one step per rng_update pulse.
  always @(posedge clk) begin
    if (gen_rst) begin
      l4 <= 4'b1011; l5 <= 5'b00111;
      b_l4 <= 4'b1011; b_l5 <= 5'b00111;
    end else begin
      if (rng_update) begin
        l4 <= {l4[2:0], l4[3] ^ l4[0]};
        l5 <= {l5[3:0], l5[4] ^ l5[2]};
      end
      if (b_rng_update) begin
        b_l4 <= {b_l4[2:0], b_l4[3] ^ b_l4[0]};
        b_l5 <= {b_l5[3:0], b_l5[4] ^ b_l5[2]};
      end
    end
  end

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rng_update)   pulses++;
    if (b_rng_update) b_pulses++;
  endtask

  task automatic gen_reset();
    gen_rst = 1'b1;
    step();
    gen_rst = 1'b0;
  endtask

  task automatic wait_query(input string tag);
    int n = 0;
    while (!occ_req && n < 100) begin
      step();
      n++;
    end
    chk_eq(tag, int'(occ_req), 1);
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; gen_rst = 1'b1;
    start = 1'b0; abort = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_ack = 1'b0; b_hit = 1'b0;
    step(); step();
    rst_n = 1'b1; gen_rst = 1'b0;
    step();

    // Reset state
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_fail", int'(fail), 0);
    chk_eq("rst_food_x", int'(food_x), 0);
    chk_eq("rst_food_y", int'(food_y), 0);
    chk_eq("rst_tries", int'(tries), 0);
    chk_eq("rst_occ_req", int'(occ_req), 0);
    chk_eq("rst_rng_update", int'(rng_update), 0);

    // Best-case placement: first candidate free
    launch();
    chk_eq("c1_rng_update", int'(rng_update), 1);
    chk_eq("c1_busy", int'(busy), 1);
    step();
    chk_eq("c2_rng_update", int'(rng_update), 0);
    chk_eq("c2_occ_req", int'(occ_req), 0);
    step();
    chk_eq("c3_occ_req", int'(occ_req), 1);
    chk_eq("c3_occ_x", int'(occ_x), 15);
    chk_eq("c3_occ_y", int'(occ_y), 6);
    occ_ack = 1'b1; occ_hit = 1'b0;
    step();
    occ_ack = 1'b0;
    chk_eq("c4_done", int'(done), 1);
    chk_eq("c4_food_x", int'(food_x), 15);
    chk_eq("c4_food_y", int'(food_y), 6);
    chk_eq("c4_tries", int'(tries), 1);
    chk_eq("c4_fail", int'(fail), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_eq("done_start_ignored", int'(busy), 0);
    chk_eq("done_pulse_one", int'(done), 0);

    // Hit, then out-of-range candidates skipped, with a stalled ack first
    gen_reset();
    pulses = 0;
    launch();
    chk_eq("retry_tries_cleared", int'(tries), 0);
    step();
    chk_eq("retry_tries_1", int'(tries), 1);
    step();
    chk_eq("retry_q1_x", int'(occ_x), 15);
    chk_eq("retry_q1_y", int'(occ_y), 6);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq("stall_occ_req", int'(occ_req), 1);
      chk_eq("stall_occ_x", int'(occ_x), 15);
      chk_eq("stall_occ_y", int'(occ_y), 6);
      chk_eq("stall_rng_update", int'(rng_update), 0);
    end
    occ_ack = 1'b1; occ_hit = 1'b1;
    step();
    occ_ack = 1'b0; occ_hit = 1'b0;
    chk_eq("hit_restep", int'(rng_update), 1);
    wait_query("retry_wait_q2");
    chk_eq("retry_q2_x", int'(occ_x), 17);
    chk_eq("retry_q2_y", int'(occ_y), 8);
    chk_eq("retry_tries_6", int'(tries), 6);
    chk_eq("retry_pulses_6", pulses, 6);
    occ_ack = 1'b1;
    step();
    occ_ack = 1'b0;
    chk_eq("retry_done", int'(done), 1);
    chk_eq("retry_food_x", int'(food_x), 17);
    chk_eq("retry_food_y", int'(food_y), 8);
    chk_eq("retry_fail", int'(fail), 0);
    step();

    // Abort beats a simultaneous free ack
    gen_reset();
    launch();
    wait_query("abort_wait_q");
    abort = 1'b1; occ_ack = 1'b1; occ_hit = 1'b0;
    step();
    abort = 1'b0; occ_ack = 1'b0;
    chk_eq("abort_busy", int'(busy), 0);
    chk_eq("abort_done", int'(done), 0);
    chk_eq("abort_occ_req", int'(occ_req), 0);
    chk_eq("abort_food_x", int'(food_x), 17);
    chk_eq("abort_food_y", int'(food_y), 8);
    step();
    chk_eq("abort_no_late_done", int'(done), 0);
    gen_reset();
    launch();
    wait_query("post_abort_wait_q");
    occ_ack = 1'b1;
    step();
    occ_ack = 1'b0;
    chk_eq("post_abort_done", int'(done), 1);
    chk_eq("post_abort_food_x", int'(food_x), 15);
    chk_eq("post_abort_food_y", int'(food_y), 6);
    step();

    // Reset during STEP
    gen_reset();
    launch();
    chk_eq("pre_rst_step", int'(rng_update), 1);
    rst_n = 1'b0; gen_rst = 1'b1;
    step();
    rst_n = 1'b1; gen_rst = 1'b0;
    chk_eq("mid_rst_busy", int'(busy), 0);
    chk_eq("mid_rst_rng_update", int'(rng_update), 0);
    chk_eq("mid_rst_tries", int'(tries), 0);
    chk_eq("mid_rst_food_x", int'(food_x), 0);
    chk_eq("mid_rst_food_y", int'(food_y), 0);
    chk_eq("mid_rst_occ_x", int'(occ_x), 0);
    launch();
    wait_query("post_rst_wait_q");
    occ_ack = 1'b1;
    step();
    occ_ack = 1'b0;
    chk_eq("post_rst_done", int'(done), 1);
    chk_eq("post_rst_food_x", int'(food_x), 15);
    chk_eq("post_rst_food_y", int'(food_y), 6);

    // MAX_TRIES=2 instance: every answer occupied -> fail after two steps
    b_pulses = 0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    begin
      int n = 0;
      while (!b_occ_req && n < 100) begin step(); n++; end
      chk_eq("b_wait_q", int'(b_occ_req), 1);
    end
    chk_eq("b_q_x", int'(b_occ_x), 15);
    chk_eq("b_q_y", int'(b_occ_y), 6);
    b_ack = 1'b1; b_hit = 1'b1;
    step();
    b_ack = 1'b0; b_hit = 1'b0;
    begin
      int n = 0;
      while (!b_done && n < 100) begin
        if (b_occ_req) begin b_ack = 1'b1; b_hit = 1'b1; end
        step();
        b_ack = 1'b0; b_hit = 1'b0;
        n++;
      end
      chk_eq("b_wait_done", int'(b_done), 1);
    end
    chk_eq("b_fail", int'(b_fail), 1);
    chk_eq("b_pulses", b_pulses, 2);
    chk_eq("b_tries", int'(b_tries), 2);
    chk_eq("b_food_x", int'(b_food_x), 0);
    chk_eq("b_food_y", int'(b_food_y), 0);
    step();
    chk_eq("b_fail_holds", int'(b_fail), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 Parameter WIDTH, default 20: playfield columns; x candidates valid in 0..WIDTH-1 (WIDTH <= 32).
REQ-002 Parameter HEIGHT, default 15: playfield rows; y candidates valid in 0..HEIGHT-1 (HEIGHT <= 16).
REQ-003 Parameter MAX_TRIES, default 31: maximum RNG steps per placement, range 1..31.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  placement request, sampled in IDLE only.
REQ-007 abort  in  1  cancel the placement in progress.
REQ-008 rng_update  out  1  one-cycle step pulse to the random generator.
REQ-009 rng4  in  4  generator 4-bit output, used as y candidate.
REQ-010 rng5  in  5  generator 5-bit output, used as x candidate.
REQ-011 occ_req  out  1  occupancy query valid.
REQ-012 occ_x  out  5  / occ_y  out  4: queried cell.
REQ-013 occ_ack  in  1  query answered this cycle.
REQ-014 occ_hit  in  1  cell occupied; valid only when occ_ack=1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 fail  out  1  with done: no free cell found; holds until next start.
REQ-018 food_x  out  5  / food_y  out  4: last placed food cell.
REQ-019 tries  out  5  RNG steps used by current/last placement.

Function
REQ-020 FSM states SHALL be IDLE, STEP, SAMPLE, QUERY, DONE.
REQ-021 IDLE: start=1 -> STEP; tries cleared to 0; fail cleared to 0.
REQ-022 STEP: rng_update=1 for exactly this cycle; tries += 1; -> SAMPLE.
REQ-023 SAMPLE: latch occ_x=rng5, occ_y=rng4 (values already stepped).
REQ-024 SAMPLE, in range (rng5<WIDTH and rng4<HEIGHT) -> QUERY.
REQ-025 SAMPLE, out of range: -> STEP if tries<MAX_TRIES, else -> DONE with fail=1.
REQ-026 QUERY: occ_req held high, occ_x/occ_y stable, until the cycle occ_ack=1.
REQ-027 QUERY, ack with occ_hit=0: food_x/food_y <= occ_x/occ_y; -> DONE, fail=0.
REQ-028 QUERY, ack with occ_hit=1: -> STEP if tries<MAX_TRIES, else -> DONE with fail=1.
REQ-029 DONE: done=1 for one cycle; -> IDLE; start during DONE ignored.
REQ-030 fail=1: food_x/food_y SHALL keep prior values.
REQ-031 Best-case latency: start seen in cycle 0, rng_update in cycle 1, occ_req from cycle 3; ack in cycle 3 gives done in cycle 4.
REQ-032 start outside IDLE SHALL be ignored; no queuing.
REQ-033 abort in any non-IDLE state -> IDLE next cycle: no done, food/fail unchanged, occ_req low from next cycle.
REQ-034 abort has priority over occ_ack in the same cycle.
REQ-035 start and abort together in IDLE: start wins.
REQ-036 rng_update SHALL never be asserted outside STEP.
REQ-037 tries SHALL never exceed MAX_TRIES; no wrap.

Reset
REQ-038 On rst_n=0 at a clock edge, next state SHALL be IDLE.
REQ-039 Reset SHALL clear rng_update, occ_req, busy, done, fail to 0; occ_x, occ_y, food_x, food_y, tries to 0.
REQ-040 Reset mid-QUERY SHALL drop occ_req in the following cycle.

Verification
REQ-041 Generator freshly reset (lfsr4=1011, lfsr5=00111); start; ack cycle 3, hit=0 -> done cycle 4, food=(15,6), tries=1, fail=0.
REQ-042 As REQ-041 but first ack hit=1 -> second candidate (31,12) rejected without occ_req; stepping continues; tries increments by 1 per rng_update.
REQ-043 MAX_TRIES=2; every ack hit=1 -> exactly 2 rng_update pulses, done with fail=1, food unchanged.
REQ-044 occ_ack withheld 5 cycles in QUERY -> occ_req and occ_x/occ_y stable throughout; no rng_update.
REQ-045 abort raised during QUERY together with occ_ack hit=0 -> IDLE, no done, food unchanged; next start works normally.
REQ-046 rst_n low during STEP -> all outputs 0 next cycle; start after release -> normal placement.
